// File: rtl/mil1553_word_rx_ctrl.sv
// MIL-STD-1553 word receive controller.
// Clears the external prefix receiver, forwards it the sync and first data bit
// half-bits, takes its verdict, then Manchester-decodes the remaining 15 data
// bits plus the parity bit locally and reports one word or one error pulse.
module mil1553_word_rx_ctrl #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_enable,
   input  logic        i_rx_in,
   input  logic        i_rx_valid,
   output logic        o_pfx_rx_in,
   output logic        o_pfx_rx_valid,
   output logic        o_pfx_clear,
   input  logic        i_pfx_busy,
   input  logic        i_pfx_done,
   input  logic        i_pfx_fail,
   input  logic        i_pfx_word_type,
   input  logic        i_pfx_data_bit,
   output logic        o_busy,
   output logic [15:0] o_word,
   output logic        o_word_type,
   output logic        o_word_valid,
   output logic        o_err_sync,
   output logic        o_err_manchester,
   output logic        o_err_parity,
   output logic        o_err_timeout
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CLEAR  = 2'd1,
      ST_PREFIX = 2'd2,
      ST_DATA   = 2'd3
   } state_t;

   // Odd parity holds when the data bits and the parity bit XOR to one.
   function automatic logic parity_odd_ok(input logic [15:0] word, input logic par);
      parity_odd_ok = (^word) ^ par;
   endfunction

   state_t           state_q, state_d;
   logic             seen_q, seen_d;          // a half-bit was forwarded in PREFIX
   logic [TMO_W-1:0] tmo_q, tmo_d;            // idle cycles since last accepted half-bit
   logic [4:0]       hcnt_q, hcnt_d;          // DATA half-bit index; bit 0 = second half
   logic             first_q, first_d;        // first half of the current pair
   logic [15:0]      shreg_q, shreg_d;
   logic             type_q, type_d;
   logic [15:0]      word_q, word_d;
   logic             word_type_q, word_type_d;
   logic             valid_q, valid_d;
   logic             esync_q, esync_d;
   logic             eman_q, eman_d;
   logic             epar_q, epar_d;
   logic             etmo_q, etmo_d;
   logic             busy_q, busy_d;
   logic             clear_q, clear_d;
   logic [TMO_W-1:0] tmo_inc_s;
   logic             tmo_exp_s;
   logic             unused_s;

   // The prefix receiver's busy flag is informational; sequencing keys off done.
   assign unused_s = i_pfx_busy;

   assign tmo_inc_s = tmo_q + TMO_ONE;
   assign tmo_exp_s = (tmo_q == TMO_LAST);

   // Half-bits reach the prefix receiver only while it still wants them.
   assign o_pfx_rx_in    = i_rx_in;
   assign o_pfx_rx_valid = i_rx_valid && (state_q == ST_PREFIX) && !i_pfx_done;

   // Next-state, datapath and pulse decode; disable forces IDLE with no pulses.
   always_comb begin
      state_d     = state_q;
      seen_d      = seen_q;
      tmo_d       = tmo_q;
      hcnt_d      = hcnt_q;
      first_d     = first_q;
      shreg_d     = shreg_q;
      type_d      = type_q;
      word_d      = word_q;
      word_type_d = word_type_q;
      valid_d     = 1'b0;
      esync_d     = 1'b0;
      eman_d      = 1'b0;
      epar_d      = 1'b0;
      etmo_d      = 1'b0;
      if (!i_enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
               state_d = ST_PREFIX;
               seen_d  = 1'b0;
               tmo_d   = TMO_ZERO;
               hcnt_d  = 5'd0;
            end
            ST_PREFIX: begin
               if (i_pfx_done) begin
                  if (i_pfx_fail) begin
                     esync_d = 1'b1;
                     state_d = ST_CLEAR;
                  end else begin
                     type_d  = i_pfx_word_type;
                     shreg_d = {15'd0, i_pfx_data_bit};
                     state_d = ST_DATA;
                     // A half-bit arriving with done is already the first DATA half.
                     if (i_rx_valid) begin
                        first_d = i_rx_in;
                        hcnt_d  = 5'd1;
                        tmo_d   = TMO_ZERO;
                     end else begin
                        hcnt_d  = 5'd0;
                        tmo_d   = tmo_exp_s ? tmo_q : tmo_inc_s;
                     end
                  end
               end else if (i_rx_valid) begin
                  seen_d = 1'b1;
                  tmo_d  = TMO_ZERO;
               end else if (seen_q) begin
                  if (tmo_exp_s) begin
                     etmo_d  = 1'b1;
                     state_d = ST_CLEAR;
                  end else begin
                     tmo_d = tmo_inc_s;
                  end
               end else begin
                  tmo_d = TMO_ZERO;
               end
            end
            ST_DATA: begin
               if (i_rx_valid) begin
                  tmo_d = TMO_ZERO;
                  if (!hcnt_q[0]) begin
                     first_d = i_rx_in;
                     hcnt_d  = hcnt_q + 5'd1;
                  end else if (first_q == i_rx_in) begin
                     eman_d  = 1'b1;
                     state_d = ST_CLEAR;
                  end else if (hcnt_q == 5'd31) begin
                     // Final pair carries parity; the word is complete.
                     word_d      = shreg_q;
                     word_type_d = type_q;
                     if (parity_odd_ok(shreg_q, first_q)) begin
                        valid_d = 1'b1;
                     end else begin
                        epar_d = 1'b1;
                     end
                     state_d = ST_CLEAR;
                  end else begin
                     shreg_d = {shreg_q[14:0], first_q};
                     hcnt_d  = hcnt_q + 5'd1;
                  end
               end else if (tmo_exp_s) begin
                  etmo_d  = 1'b1;
                  state_d = ST_CLEAR;
               end else begin
                  tmo_d = tmo_inc_s;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
      busy_d  = (state_d == ST_DATA) || ((state_d == ST_PREFIX) && seen_d);
      clear_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         seen_q      <= 1'b0;
         tmo_q       <= TMO_ZERO;
         hcnt_q      <= 5'd0;
         first_q     <= 1'b0;
         shreg_q     <= 16'd0;
         type_q      <= 1'b0;
         word_q      <= 16'd0;
         word_type_q <= 1'b0;
         valid_q     <= 1'b0;
         esync_q     <= 1'b0;
         eman_q      <= 1'b0;
         epar_q      <= 1'b0;
         etmo_q      <= 1'b0;
         busy_q      <= 1'b0;
         clear_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         seen_q      <= seen_d;
         tmo_q       <= tmo_d;
         hcnt_q      <= hcnt_d;
         first_q     <= first_d;
         shreg_q     <= shreg_d;
         type_q      <= type_d;
         word_q      <= word_d;
         word_type_q <= word_type_d;
         valid_q     <= valid_d;
         esync_q     <= esync_d;
         eman_q      <= eman_d;
         epar_q      <= epar_d;
         etmo_q      <= etmo_d;
         busy_q      <= busy_d;
         clear_q     <= clear_d;
      end
   end

   assign o_busy           = busy_q;
   assign o_pfx_clear      = clear_q;
   assign o_word           = word_q;
   assign o_word_type      = word_type_q;
   assign o_word_valid     = valid_q;
   assign o_err_sync       = esync_q;
   assign o_err_manchester = eman_q;
   assign o_err_parity     = epar_q;
   assign o_err_timeout    = etmo_q;

endmodule
